// File: rtl/serial_gt_cmp.sv
// Bit-serial MSB-first magnitude comparator: one bit per clock, start/done handshake,
// registered one-hot agtb/aeqb/altb flags held until the next accepted start.
module serial_gt_cmp #(
    parameter int W          = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         agtb,
    output logic         aeqb,
    output logic         altb
);
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          gt_q, gt_d, lt_q, lt_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          agtb_q, agtb_d, aeqb_q, aeqb_d, altb_q, altb_d;
    logic          bit_gt, bit_lt;

    assign bit_gt = a_q[idx_q] & ~b_q[idx_q];
    assign bit_lt = ~a_q[idx_q] & b_q[idx_q];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        agtb_d  = agtb_q;
        aeqb_d  = aeqb_q;
        altb_d  = altb_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IW'(W - 1);
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    agtb_d  = 1'b0;
                    aeqb_d  = 1'b0;
                    altb_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Only the most significant difference decides; later bits never overwrite it.
                if (!gt_q && !lt_q) begin
                    gt_d = bit_gt;
                    lt_d = bit_lt;
                end
                if ((EARLY_EXIT && (bit_gt || bit_lt)) || (idx_q == '0)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    agtb_d  = gt_d;
                    altb_d  = lt_d;
                    aeqb_d  = ~(gt_d | lt_d);
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            agtb_q  <= 1'b0;
            aeqb_q  <= 1'b0;
            altb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            agtb_q  <= agtb_d;
            aeqb_q  <= aeqb_d;
            altb_q  <= altb_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign agtb = agtb_q;
    assign aeqb = aeqb_q;
    assign altb = altb_q;
endmodule
